// File: rtl/demux1x2_tdm_pkg.sv
// rtl/demux1x2_tdm_pkg.sv - shared constants and helpers for the 1:2 TDM demux
package demux1x2_tdm_pkg;

    localparam logic [0:0] ST_HUNT = 1'b0;
    localparam logic [0:0] ST_LOCK = 1'b1;

    localparam int W_DEFAULT     = 8;
    localparam int DEPTH_DEFAULT = 2;

    // A sync beat always lands in ch0; otherwise the slot pointer decides.
    function automatic logic [0:0] tgt_of(input logic sync, input logic [0:0] sel);
        return sync ? 1'b0 : sel;
    endfunction

endpackage

// File: rtl/demux1x2_tdm_sync_fifo.sv
// rtl/demux1x2_tdm_sync_fifo.sv - per-channel synchronous FIFO
module sync_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] din,
    output logic         full,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          do_push;
    logic          do_pop;

    assign full    = (cnt_q == CNT_FULL);
    assign empty   = (cnt_q == '0);
    assign dout    = mem_q[rd_ptr_q];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage is not reset; the empty flag masks stale contents.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/demux1x2_tdm.sv
// rtl/demux1x2_tdm.sv - splits a ch0/ch1 time-multiplexed stream into two FIFO'd channels
module demux1x2_tdm
    import demux1x2_tdm_pkg::*;
#(
    parameter int W     = W_DEFAULT,
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    input  logic         in_sync,
    output logic         out0_valid,
    input  logic         out0_ready,
    output logic [W-1:0] out0_data,
    output logic         out1_valid,
    input  logic         out1_ready,
    output logic [W-1:0] out1_data,
    output logic         sync_err,
    output logic [7:0]   err_cnt
);

    logic [0:0] state_q, state_d;
    logic [0:0] sel_q, sel_d;
    logic       sync_err_q, sync_err_d;
    logic [7:0] err_cnt_q, err_cnt_d;

    logic [0:0] tgt;
    logic       full0, full1, empty0, empty1;
    logic       tgt_full;
    logic       accept;
    logic       push0, push1;
    logic       locked;

    assign locked   = (state_q == ST_LOCK);
    assign tgt      = tgt_of(in_sync, sel_q);
    assign tgt_full = (tgt == 1'b1) ? full1 : full0;
    // No pop bypass: a full target stalls even if its consumer drains this cycle.
    assign in_ready = locked ? ~tgt_full : 1'b1;
    assign accept   = in_valid & in_ready;

    assign push0 = accept & (locked ? (tgt == 1'b0) : in_sync);
    assign push1 = accept & locked & (tgt == 1'b1);

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        sync_err_d = 1'b0;
        err_cnt_d  = err_cnt_q;
        if (accept) begin
            if (!locked) begin
                if (in_sync) begin
                    state_d = ST_LOCK;
                    sel_d   = 1'b1;
                end
            end else begin
                sel_d = ~tgt;
                if (in_sync && sel_q == 1'b1) begin
                    sync_err_d = 1'b1;
                    if (err_cnt_q != 8'hFF) begin
                        err_cnt_d = err_cnt_q + 8'd1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_HUNT;
            sel_q      <= 1'b0;
            sync_err_q <= 1'b0;
            err_cnt_q  <= 8'd0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            sync_err_q <= sync_err_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign sync_err = sync_err_q;
    assign err_cnt  = err_cnt_q;

    sync_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo0 (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push0),
        .din   (in_data),
        .full  (full0),
        .pop   (out0_ready),
        .dout  (out0_data),
        .empty (empty0)
    );

    sync_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo1 (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push1),
        .din   (in_data),
        .full  (full1),
        .pop   (out1_ready),
        .dout  (out1_data),
        .empty (empty1)
    );

    assign out0_valid = ~empty0;
    assign out1_valid = ~empty1;

endmodule
